// File: rtl/apb_master_engine.sv
// apb_master_engine
// APB4 master for the AXI-to-APB bridge. Accepts one transfer at a time on a
// valid/ready request channel, decodes the target slave from the address,
// runs the SETUP/ACCESS handshake with byte strobes, and returns read data
// and error status on a valid/ready response channel. An unclaimed slave
// index (decode error) and a stalled PREADY (timeout) are both reported as
// errors without hanging the engine.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (req_ready = engine idle)
//   req_write/addr/wdata/strb request payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    response payload
//   PADDR..PSTRB             APB request side (PSEL is one-hot per slave)
//   PRDATA/PREADY/PSLVERR    per-slave APB return signals
module apb_master_engine #(
   parameter int unsigned ADDRESS_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned NUM_SLAVES      = 4,
   parameter int unsigned SLAVE_ADDR_BITS = 12,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   // request channel
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDRESS_WIDTH-1:0]         req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   input  logic [DATA_WIDTH/8-1:0]          req_strb,
   // response channel
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic                             rsp_timeout,
   // APB master side
   output logic [ADDRESS_WIDTH-1:0]         PADDR,
   output logic [NUM_SLAVES-1:0]            PSEL,
   output logic                             PENABLE,
   output logic                             PWRITE,
   output logic [DATA_WIDTH-1:0]            PWDATA,
   output logic [DATA_WIDTH/8-1:0]          PSTRB,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]            PREADY,
   input  logic [NUM_SLAVES-1:0]            PSLVERR
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                     state_q,       state_d;
   logic [IDX_W-1:0]           idx_q,         idx_d;
   logic [CNT_W-1:0]           cnt_q,         cnt_d;
   logic [ADDRESS_WIDTH-1:0]   paddr_q,       paddr_d;
   logic [NUM_SLAVES-1:0]      psel_q,        psel_d;
   logic                       penable_q,     penable_d;
   logic                       pwrite_q,      pwrite_d;
   logic [DATA_WIDTH-1:0]      pwdata_q,      pwdata_d;
   logic [STRB_W-1:0]          pstrb_q,       pstrb_d;
   logic                       rsp_valid_q,   rsp_valid_d;
   logic [DATA_WIDTH-1:0]      rsp_rdata_q,   rsp_rdata_d;
   logic                       rsp_err_q,     rsp_err_d;
   logic                       rsp_timeout_q, rsp_timeout_d;

   logic [IDX_W-1:0]           req_idx_c;
   logic                       decode_ok_c;
   logic [DATA_WIDTH-1:0]      sel_rdata_c;
   logic                       sel_ready_c;
   logic                       sel_err_c;

   // Slave index field sits just above the per-slave window; higher bits alias.
   if (NUM_SLAVES > 1) begin : g_decode
      assign req_idx_c = req_addr[SLAVE_ADDR_BITS +: IDX_W];
   end else begin : g_decode_single
      assign req_idx_c = '0;
   end

   // Only reachable when NUM_SLAVES is not a power of two.
   assign decode_ok_c = (32'(req_idx_c) < NUM_SLAVES);

   // Return-path mux: only the latched slave's signals are observed.
   always_comb begin
      sel_rdata_c = '0;
      sel_ready_c = 1'b0;
      sel_err_c   = 1'b0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_rdata_c = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            sel_ready_c = PREADY[i];
            sel_err_c   = PSLVERR[i];
         end
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      paddr_d       = paddr_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (decode_ok_c) begin
                  paddr_d   = req_addr;
                  pwrite_d  = req_write;
                  pwdata_d  = req_wdata;
                  pstrb_d   = req_write ? req_strb : '0;
                  idx_d     = req_idx_c;
                  psel_d    = NUM_SLAVES'(1) << req_idx_c;
                  penable_d = 1'b0;
                  state_d   = ST_SETUP;
               end else begin
                  // Decode error: answer directly, the APB bus stays quiet.
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
                  state_d       = ST_RESP;
               end
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
            // PREADY is checked first so it wins over a same-cycle timeout.
            if (sel_ready_c) begin
               rsp_rdata_d   = (!pwrite_q && !sel_err_c) ? sel_rdata_c : '0;
               rsp_err_d     = sel_err_c;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = '0;
               penable_d     = 1'b0;
               state_d       = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = '0;
               penable_d     = 1'b0;
               state_d       = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         cnt_q         <= '0;
         paddr_q       <= '0;
         psel_q        <= '0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         paddr_q       <= paddr_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign PADDR       = paddr_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign PSTRB       = pstrb_q;

endmodule
